acc_cpu_core: RTL and testbench

//  Parametrised accumulator CPU core; next generation of the 8-bit RISC top level.
//  - Replaces clkgen phases and the tri-state mdat bus with one FSM and a req/ack memory port.
//  - Data width and address width are parameters; memory may insert wait states.
//  - Adds a carry flag, a halt/run handshake and debug visibility of pc/acc.
//  - Program loading is done by the memory owner while halted=1; it is not part of this block.

---
 rtl/acc_cpu_pkg.sv | 23 ++
 rtl/acc_cpu_alu.sv | 32 +++
 rtl/acc_cpu_core.sv | 150 +++++++++++++++
 tb/tb_acc_cpu_core.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core: opcode values, opcode-field width, FSM states.
package acc_cpu_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_HLT = 3'b000;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
    localparam logic [OPC_W-1:0] OP_AND = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OP_LDA = 3'b101;
    localparam logic [OPC_W-1:0] OP_STO = 3'b110;
    localparam logic [OPC_W-1:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_WRITE
    } state_t;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU of the accumulator CPU: ADD (with carry-out), AND, XOR and LDA pass-through.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mdat,
    input  logic [OPC_W-1:0]  opcd,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, acc} + {1'b0, mdat};

    always_comb begin
        result = mdat;
        carry  = 1'b0;
        case (opcd)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_AND:  result = acc & mdat;
            OP_XOR:  result = acc ^ mdat;
            default: result = mdat;
        endcase
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: single FSM driving a req/ack memory port, with pc, ir, acc and carry state.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              zr,
    output logic              cy,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc
);

    if (DATA_W < 4 || DATA_W > 32 || ADDR_W > DATA_W - OPC_W) begin : g_param_check
        $error("acc_cpu_core: DATA_W must be 4..32 and ADDR_W <= DATA_W-3");
    end

    state_t              state, state_nx;
    logic [DATA_W-1:0]   ir, ir_nx, acc_nx, alu_result;
    logic [ADDR_W-1:0]   pc_nx, addr_nx, pc_inc, operand;
    logic [OPC_W-1:0]    opcode;
    logic                cy_nx, req_nx, we_nx, alu_carry;

    assign opcode    = ir[DATA_W-1 -: OPC_W];
    assign operand   = ir[ADDR_W-1:0];
    assign pc_inc    = pc + ADDR_W'(1);
    assign halted    = (state == S_IDLE);
    assign zr        = (acc == '0);
    assign mem_wdata = acc;

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .acc    (acc),
        .mdat   (mem_rdata),
        .opcd   (opcode),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Port outputs are registered: next-cycle req/we/addr are chosen here so the
    // bus never depends combinationally on mem_ack or mem_rdata.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        acc_nx   = acc;
        cy_nx    = cy;
        req_nx   = mem_req;
        we_nx    = mem_we;
        addr_nx  = mem_addr;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_FETCH;
                    req_nx   = 1'b1;
                    we_nx    = 1'b0;
                    addr_nx  = pc;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_nx    = mem_rdata;
                    pc_nx    = pc_inc;
                    req_nx   = 1'b0;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                req_nx   = 1'b1;
                we_nx    = 1'b0;
                addr_nx  = operand;
                state_nx = S_READ;
                case (opcode)
                    OP_HLT: begin
                        req_nx   = 1'b0;
                        addr_nx  = mem_addr;
                        state_nx = S_IDLE;
                    end
                    OP_SKZ: begin
                        pc_nx    = zr ? pc_inc : pc;
                        addr_nx  = pc_nx;
                        state_nx = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_nx    = operand;
                        state_nx = S_FETCH;
                    end
                    OP_STO: begin
                        we_nx    = 1'b1;
                        state_nx = S_WRITE;
                    end
                    default: state_nx = S_READ;
                endcase
            end
            S_READ: begin
                // req stays high: the next fetch follows back-to-back.
                if (mem_ack) begin
                    acc_nx   = alu_result;
                    if (opcode == OP_ADD) cy_nx = alu_carry;
                    addr_nx  = pc;
                    state_nx = S_FETCH;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    we_nx    = 1'b0;
                    addr_nx  = pc;
                    state_nx = S_FETCH;
                end
            end
            default: begin
                req_nx   = 1'b0;
                we_nx    = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            acc      <= '0;
            cy       <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ir       <= ir_nx;
            acc      <= acc_nx;
            cy       <= cy_nx;
            mem_req  <= req_nx;
            mem_we   <= we_nx;
            mem_addr <= addr_nx;
        end
    end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: wait-state memory with transfer scoreboard, ISA-level reference model.
module tb_acc_cpu_core;

    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int TW   = 1 + AW + DW;
    localparam int MEMN = 1 << AW;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          run, mem_req, mem_we, mem_ack, halted, zr, cy;
    logic [AW-1:0] mem_addr, pc;
    logic [DW-1:0] mem_wdata, mem_rdata, acc;

    acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted), .zr(zr), .cy(cy), .pc(pc), .acc(acc)
    );

    // wide instance: 16-bit data, 8-bit address, zero-wait memory
    logic        w_run, w_req, w_we, w_ack, w_halted, w_zr, w_cy;
    logic [7:0]  w_addr, w_pc;
    logic [15:0] w_wdata, w_rdata, w_acc;
    logic [15:0] w_mem [256];

    acc_cpu_core #(.DATA_W(16), .ADDR_W(8)) dut_wide (
        .clk(clk), .rst(rst), .run(w_run),
        .mem_req(w_req), .mem_we(w_we), .mem_addr(w_addr),
        .mem_wdata(w_wdata), .mem_rdata(w_rdata), .mem_ack(w_ack),
        .halted(w_halted), .zr(w_zr), .cy(w_cy), .pc(w_pc), .acc(w_acc)
    );

    assign w_ack   = w_req;
    assign w_rdata = w_mem[w_addr];

    initial begin
        for (int i = 0; i < 256; i++) w_mem[i] = 16'h0000;
        w_mem[0]  = 16'hA00A;
        w_mem[1]  = 16'h400B;
        w_mem[2]  = 16'hC00C;
        w_mem[10] = 16'h0005;
        w_mem[11] = 16'h0003;
        forever begin
            @(negedge clk);
            if (w_req && w_we) w_mem[w_addr] = w_wdata;
        end
    end

    // scoreboard state and reference model
    logic [TW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] tb_mem [MEMN];
    logic [DW-1:0] m_mem  [MEMN];
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_acc;
    logic          m_cy;
    int            max_wait   = 0;
    bit            spurious   = 0;
    bit            hold_write = 0;
    int            wait_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ISA interpreter: runs until HLT, queues every expected bus transfer and
    // returns the zero-wait cycle count (2 for HLT/SKZ/JMP, 3 otherwise).
    task automatic model_run(output int cyc);
        logic [DW-1:0] ir;
        logic [2:0]    op;
        logic [AW-1:0] opnd;
        int            sum;
        cyc = 0;
        for (int n = 0; n < 200; n++) begin
            exp_q.push_back({1'b0, m_pc, DW'(0)});
            ir   = m_mem[m_pc];
            m_pc = m_pc + AW'(1);
            op   = ir[DW-1 -: 3];
            opnd = ir[AW-1:0];
            if (op == 3'd0) begin
                cyc += 2;
                break;
            end
            case (op)
                3'd1: begin
                    cyc += 2;
                    if (m_acc == 0) m_pc = m_pc + AW'(1);
                end
                3'd7: begin
                    cyc += 2;
                    m_pc = opnd;
                end
                3'd6: begin
                    cyc += 3;
                    exp_q.push_back({1'b1, opnd, m_acc});
                    m_mem[opnd] = m_acc;
                end
                default: begin
                    cyc += 3;
                    exp_q.push_back({1'b0, opnd, DW'(0)});
                    case (op)
                        3'd2: begin
                            sum   = int'(m_acc) + int'(m_mem[opnd]);
                            m_cy  = (sum >= (1 << DW));
                            m_acc = DW'(sum);
                        end
                        3'd3:    m_acc = m_acc & m_mem[opnd];
                        3'd4:    m_acc = m_acc ^ m_mem[opnd];
                        default: m_acc = m_mem[opnd];
                    endcase
                end
            endcase
        end
    endtask

    // memory model + monitor: random wait states, optional spurious acks while idle
    bit            busy;
    int            waits;
    logic [AW-1:0] t_addr;
    logic          t_we;
    logic [DW-1:0] t_wdata;

    initial begin
        busy = 0;
        waits = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst) begin
                busy = 0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy    = 1;
                    t_addr  = mem_addr;
                    t_we    = mem_we;
                    t_wdata = mem_wdata;
                    waits   = $urandom_range(0, max_wait);
                    wait_total += waits;
                end else begin
                    check("addr_stable", mem_addr, t_addr);
                    check("we_stable", mem_we, t_we);
                    check("wdata_stable", mem_wdata, t_wdata);
                end
                if (!(hold_write && t_we)) begin
                    if (waits == 0) begin
                        mem_ack = 1'b1;
                        busy    = 0;
                        if (t_we) tb_mem[t_addr] = t_wdata;
                        else      mem_rdata = tb_mem[t_addr];
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_transfer: got we=%0b addr=%0h expected none", t_we, t_addr);
                        end else begin
                            check("transfer", {t_we, t_addr, t_we ? t_wdata : DW'(0)}, exp_q.pop_front());
                        end
                    end else begin
                        waits--;
                    end
                end
            end else if (spurious && $urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = DW'($urandom);
            end
        end
    end

    // driver tasks
    task automatic clear_mem();
        for (int i = 0; i < MEMN; i++) tb_mem[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_pc  = '0;
        m_acc = '0;
        m_cy  = 1'b0;
        exp_q.delete();
    endtask

    task automatic prog1(input logic [DW-1:0] a, input logic [DW-1:0] b);
        clear_mem();
        tb_mem[0]  = 8'hAA;
        tb_mem[1]  = 8'h4B;
        tb_mem[2]  = 8'hCC;
        tb_mem[3]  = 8'h00;
        tb_mem[10] = a;
        tb_mem[11] = b;
        m_mem = tb_mem;
    endtask

    task automatic run_segment(input string tag, output int cycles);
        int exp_cyc;
        int w0;
        model_run(exp_cyc);
        w0 = wait_total;
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        check($sformatf("%s_req_after_run", tag), mem_req, 1);
        cycles = 0;
        while (!halted && cycles < 3000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check($sformatf("%s_halted", tag), halted, 1);
        check($sformatf("%s_cycles", tag), cycles, exp_cyc + (wait_total - w0));
        check($sformatf("%s_acc", tag), acc, m_acc);
        check($sformatf("%s_cy", tag), cy, m_cy);
        check($sformatf("%s_zr", tag), zr, m_acc == 0);
        check($sformatf("%s_pc", tag), pc, m_pc);
        check($sformatf("%s_pending", tag), exp_q.size(), 0);
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < MEMN; a++)
            check($sformatf("%s_mem%0d", tag, a), tb_mem[a], m_mem[a]);
    endtask

    // stimulus
    int cyc;

    initial begin
        run   = 1'b0;
        w_run = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_halted", halted, 1);
        check("rst_zr", zr, 1);
        check("rst_pc", pc, 0);
        check("rst_acc", acc, 0);
        check("rst_cy", cy, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        do_reset();

        // LDA/ADD/STO/HLT, zero wait
        prog1(8'h05, 8'h03);
        run_segment("t1", cyc);
        check("t1_cycles_const", cyc, 11);
        check("t1_mem12", tb_mem[12], 8'h08);
        check("t1_acc_const", acc, 8'h08);
        check("t1_cy_const", cy, 0);
        check("t1_pc_const", pc, 4);

        // carry out of ADD
        do_reset();
        prog1(8'hF0, 8'h20);
        run_segment("t2", cyc);
        check("t2_acc_const", acc, 8'h10);
        check("t2_cy_const", cy, 1);
        check("t2_mem12", tb_mem[12], 8'h10);

        // SKZ skips JMP 7 when acc is zero
        do_reset();
        clear_mem();
        tb_mem[0] = 8'hB4; tb_mem[1] = 8'h20; tb_mem[2] = 8'hE7; tb_mem[3] = 8'h00;
        m_mem = tb_mem;
        run_segment("t3", cyc);
        check("t3_pc_const", pc, 4);
        check("t3_zr_const", zr, 1);

        // wait states
        do_reset();
        max_wait = 3;
        prog1(8'h05, 8'h03);
        run_segment("t4", cyc);
        check("t4_mem12", tb_mem[12], 8'h08);
        check("t4_acc_const", acc, 8'h08);

        // JMP 31, SKZ at 31 wraps pc to 1
        do_reset();
        max_wait = 0;
        clear_mem();
        tb_mem[0] = 8'hFF; tb_mem[31] = 8'h20; tb_mem[1] = 8'h00;
        m_mem = tb_mem;
        run_segment("t5", cyc);
        check("t5_pc_const", pc, 2);
        check("t5_cycles_const", cyc, 6);

        // random programs: code in 0..15 (forward jumps only), data in 16..31
        max_wait = 3;
        spurious = 1;
        for (int r = 0; r < 6; r++) begin
            int segs;
            do_reset();
            for (int i = 0; i < MEMN; i++) begin
                if (i >= 14 && i < 16) begin
                    tb_mem[i] = '0;
                end else if (i < 14) begin
                    logic [2:0]    op;
                    logic [AW-1:0] opnd;
                    op   = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                    opnd = (op == 3'd7) ? AW'($urandom_range(i + 1, 15)) : AW'($urandom_range(16, 31));
                    tb_mem[i] = {op, opnd};
                end else begin
                    tb_mem[i] = ($urandom_range(0, 3) == 0) ? DW'(0) : DW'($urandom_range(0, 255));
                end
            end
            m_mem = tb_mem;
            segs = 0;
            while (m_pc < 16 && segs < 16) begin
                run_segment($sformatf("rnd%0d_%0d", r, segs), cyc);
                segs++;
            end
            check_mem($sformatf("rnd%0d", r));
        end
        spurious = 0;
        max_wait = 0;

        // reset during a stalled WRITE
        do_reset();
        clear_mem();
        tb_mem[0] = 8'hCC; tb_mem[1] = 8'h00;
        m_mem = tb_mem;
        model_run(cyc);
        hold_write = 1;
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        for (int k = 0; k < 20 && !(mem_req && mem_we); k++) @(negedge clk);
        check("t6_write_seen", mem_req && mem_we, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_req_drop", mem_req, 0);
        check("t6_we_drop", mem_we, 0);
        check("t6_pc", pc, 0);
        check("t6_acc", acc, 0);
        check("t6_halted", halted, 1);
        @(negedge clk);
        rst        = 1'b0;
        hold_write = 0;
        m_pc  = '0;
        m_acc = '0;
        m_cy  = 1'b0;
        exp_q.delete();
        check("t6_no_write", tb_mem[12], 0);
        m_mem = tb_mem;
        run_segment("t6", cyc);
        check("t6_pc_const", pc, 2);

        // wide instance runs the first program
        @(negedge clk);
        w_run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w_run = 1'b0;
        for (int k = 0; k < 100 && !w_halted; k++) @(negedge clk);
        check("w_halted", w_halted, 1);
        check("w_acc", w_acc, 16'h0008);
        check("w_cy", w_cy, 0);
        check("w_zr", w_zr, 0);
        check("w_pc", w_pc, 8'h04);
        check("w_mem12", w_mem[12], 16'h0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
